instr_seq: RTL and testbench

INSTR_SEQ -- requirements
Module: instr_seq

---
 rtl/instr_seq_if.sv | 42 ++++
 rtl/instr_seq.sv | 159 +++++++++++++++
 tb/tb_instr_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_seq_if.sv
// ---------------------------------------------------------------------------
// instr_seq_if : bundle of all non-clock/reset signals of instr_seq.
//
//   instrIn/instrValid/instrReady : instruction handshake into the sequencer
//   rdDataA/rdDataB/opSelect      : operands and operation sent to the ALU
//   aluIn                         : combinational ALU result returned
//   wbValid/wbAddr/wbData         : register write-back report
//   errIllegal                    : illegal-opcode pulse
//   retired                       : count of written-back instructions
//
// Modports: slave  = the sequencer (instr_seq)
//           master = the environment (instruction source + ALU)
// ---------------------------------------------------------------------------
interface instr_seq_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
);
    logic [DATA_W-1:0]     instrIn;
    logic                  instrValid;
    logic                  instrReady;
    logic [DATA_W-1:0]     rdDataA;
    logic [DATA_W-1:0]     rdDataB;
    logic [1:0]            opSelect;
    logic [DATA_W-1:0]     aluIn;
    logic                  wbValid;
    logic [REG_ADDR_W-1:0] wbAddr;
    logic [DATA_W-1:0]     wbData;
    logic                  errIllegal;
    logic [DATA_W-1:0]     retired;

    modport master (
        output instrIn, instrValid, aluIn,
        input  instrReady, rdDataA, rdDataB, opSelect,
               wbValid, wbAddr, wbData, errIllegal, retired
    );

    modport slave (
        input  instrIn, instrValid, aluIn,
        output instrReady, rdDataA, rdDataB, opSelect,
               wbValid, wbAddr, wbData, errIllegal, retired
    );
endinterface

// File: rtl/instr_seq.sv
// ---------------------------------------------------------------------------
// instr_seq : four-state instruction sequencer with an 8 x 16-bit register
// file, driving an external combinational ALU.
//
// Ports:
//   clk   - single clock, rising edge
//   rstN  - asynchronous active-low reset
//   bus   - instr_seq_if.slave (handshake, ALU operands/result, write-back,
//           illegal-opcode pulse, retired counter)
//
// Instruction word: [15:13] op, [12:10] rd, [9:7] ra, [6:4] rb, [9:0] imm.
//   op 000 add, 001 sub, 010 nand, 011 pass B, 100 LDI, 101-111 illegal.
//
// Sequence: IDLE -> DECODE -> EXEC -> WB -> IDLE (illegal ops: DECODE -> IDLE).
//
// Optional feature: define INSTR_SEQ_ZERO_REG_EN to hard-wire R0 to zero.
// ---------------------------------------------------------------------------
module instr_seq #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic       clk,
    input  logic       rstN,
    instr_seq_if.slave bus
);
    localparam int NUM_REGS = 1 << REG_ADDR_W;
    localparam int IMM_W    = 10;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0]     instr_q;
    logic [DATA_W-1:0]     regs [NUM_REGS];
    logic [DATA_W-1:0]     rd_data_a_q;
    logic [DATA_W-1:0]     rd_data_b_q;
    logic [1:0]            op_select_q;
    logic [DATA_W-1:0]     result_q;
    logic [REG_ADDR_W-1:0] wb_addr_q;
    logic                  wb_valid_q;
    logic                  err_illegal_q;
    logic [DATA_W-1:0]     retired_q;

    logic [2:0]            op;
    logic [REG_ADDR_W-1:0] rd, ra, rb;
    logic [IMM_W-1:0]      imm;
    logic                  is_alu_op;
    logic                  is_ldi;
    logic                  reg_we;

    function automatic logic signed [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] v);
        return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
    endfunction

    // Instruction fields come from the captured word, so they stay stable
    // through DECODE, EXEC and WB.
    assign op        = instr_q[15:13];
    assign rd        = instr_q[12:10];
    assign ra        = instr_q[9:7];
    assign rb        = instr_q[6:4];
    assign imm       = instr_q[9:0];
    assign is_alu_op = (op[2] == 1'b0);
    assign is_ldi    = (op == 3'b100);

`ifdef INSTR_SEQ_ZERO_REG_EN
    // R0 is reset to zero and never written, so it always reads zero; the
    // write-back report and retired count are unaffected.
    assign reg_we = (state_q == WB) && (rd != '0);
`else
    assign reg_we = (state_q == WB);
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.instrValid) state_d = DECODE;
            DECODE:  state_d = (is_alu_op || is_ldi) ? EXEC : IDLE;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Register file: written only on the WB -> IDLE edge, so a following
    // instruction's DECODE already sees the new value (no forwarding needed).
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[rd] <= result_q;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            instr_q       <= '0;
            rd_data_a_q   <= '0;
            rd_data_b_q   <= '0;
            op_select_q   <= '0;
            result_q      <= '0;
            wb_addr_q     <= '0;
            wb_valid_q    <= 1'b0;
            err_illegal_q <= 1'b0;
            retired_q     <= '0;
        end else begin
            wb_valid_q    <= 1'b0;
            err_illegal_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.instrValid) instr_q <= bus.instrIn;
                end
                DECODE: begin
                    if (is_alu_op) begin
                        rd_data_a_q <= regs[ra];
                        rd_data_b_q <= regs[rb];
                        op_select_q <= op[1:0];
                    end else if (is_ldi) begin
                        // LDI goes through the ALU as "pass B"; A is left alone.
                        rd_data_b_q <= sext_imm(imm);
                        op_select_q <= 2'b11;
                    end else begin
                        err_illegal_q <= 1'b1;
                    end
                end
                EXEC: begin
                    // result_q doubles as wbData, so it holds between writes.
                    result_q   <= bus.aluIn;
                    wb_addr_q  <= rd;
                    wb_valid_q <= 1'b1;
                end
                WB: begin
                    retired_q <= retired_q + DATA_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.instrReady = (state_q == IDLE);
    assign bus.rdDataA    = rd_data_a_q;
    assign bus.rdDataB    = rd_data_b_q;
    assign bus.opSelect   = op_select_q;
    assign bus.wbValid    = wb_valid_q;
    assign bus.wbAddr     = wb_addr_q;
    assign bus.wbData     = result_q;
    assign bus.errIllegal = err_illegal_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_instr_seq.sv
// ---------------------------------------------------------------------------
// tb_instr_seq : self-checking bench for instr_seq.
// Table of instructions with hand-computed write-back, operand and retired
// values, plus a hand-written reset-in-flight sequence.
// ---------------------------------------------------------------------------
module tb_instr_seq;
    logic clk = 1'b0;
    logic rstN;

    instr_seq_if ifc ();

    instr_seq dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (ifc)
    );

    always #5 clk = ~clk;

    // External combinational ALU.
    always_comb begin
        ifc.aluIn = 16'h0000;
        case (ifc.opSelect)
            2'b00: ifc.aluIn = ifc.rdDataA + ifc.rdDataB;
            2'b01: ifc.aluIn = ifc.rdDataA - ifc.rdDataB;
            2'b10: ifc.aluIn = ~(ifc.rdDataA & ifc.rdDataB);
            2'b11: ifc.aluIn = ifc.rdDataB;
            default: ifc.aluIn = 16'h0000;
        endcase
    end

    typedef struct {
        logic [15:0] instr;
        logic        exp_err;
        logic [2:0]  exp_addr;
        logic [15:0] exp_data;
        logic [15:0] exp_retired;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic [1:0]  exp_op;
    } vec_t;

`ifdef INSTR_SEQ_ZERO_REG_EN
    localparam logic [15:0] R0_VAL = 16'h0000;
    localparam logic [15:0] R0_SUM = 16'h0000;
`else
    localparam logic [15:0] R0_VAL = 16'h0007;
    localparam logic [15:0] R0_SUM = 16'h000E;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    function automatic logic [15:0] enc_rrr(input logic [2:0] op, input logic [2:0] rd,
                                            input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 4'b0000};
    endfunction

    function automatic logic [15:0] enc_ldi(input logic [2:0] rd, input logic [9:0] imm);
        return {3'b100, rd, imm};
    endfunction

    function automatic vec_t mk(input logic [15:0] instr, input logic err,
                                input logic [2:0] addr, input logic [15:0] data,
                                input logic [15:0] ret, input logic [15:0] a,
                                input logic [15:0] b, input logic [1:0] opsel);
        vec_t v;
        v.instr = instr; v.exp_err = err; v.exp_addr = addr; v.exp_data = data;
        v.exp_retired = ret; v.exp_a = a; v.exp_b = b; v.exp_op = opsel;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (ifc.instrReady !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready_wait"}, ifc.instrReady, 1);
    endtask

    // Issue one instruction and check every cycle until it has finished.
    task automatic run_vec(input int idx, input vec_t v);
        string nm;
        nm = $sformatf("v%0d", idx);
        wait_ready(nm);
        ifc.instrIn    = v.instr;
        ifc.instrValid = 1'b1;
        @(negedge clk);                       // handshake edge k -> DECODE
        ifc.instrValid = 1'b0;
        check({nm, "_decode_ready"}, ifc.instrReady, 0);
        @(negedge clk);                       // after k+1
        check({nm, "_opA"}, ifc.rdDataA, v.exp_a);
        check({nm, "_opB"}, ifc.rdDataB, v.exp_b);
        check({nm, "_opsel"}, ifc.opSelect, v.exp_op);
        check({nm, "_wbvalid_early"}, ifc.wbValid, 0);
        if (v.exp_err) begin
            check({nm, "_err_pulse"}, ifc.errIllegal, 1);
            check({nm, "_err_ready"}, ifc.instrReady, 1);
            @(negedge clk);
            check({nm, "_err_clear"}, ifc.errIllegal, 0);
            check({nm, "_err_nowb"}, ifc.wbValid, 0);
            check({nm, "_err_retired"}, ifc.retired, v.exp_retired);
        end else begin
            check({nm, "_exec_noerr"}, ifc.errIllegal, 0);
            @(negedge clk);                   // after k+2: WB
            check({nm, "_wbvalid"}, ifc.wbValid, 1);
            check({nm, "_wbaddr"}, ifc.wbAddr, v.exp_addr);
            check({nm, "_wbdata"}, ifc.wbData, v.exp_data);
            check({nm, "_wb_ready"}, ifc.instrReady, 0);
            check({nm, "_retired_before"}, ifc.retired, 16'(v.exp_retired - 16'd1));
            @(negedge clk);                   // after k+3: write done, IDLE
            check({nm, "_wbvalid_drop"}, ifc.wbValid, 0);
            check({nm, "_ready_again"}, ifc.instrReady, 1);
            check({nm, "_retired"}, ifc.retired, v.exp_retired);
            check({nm, "_wbdata_hold"}, ifc.wbData, v.exp_data);
            check({nm, "_wbaddr_hold"}, ifc.wbAddr, v.exp_addr);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 instr                             err addr data      ret    A         B         op
        vecs.push_back(mk(enc_ldi(3'd1, 10'd5),             0, 1, 16'h0005, 16'd1,  16'h0000, 16'h0005, 2'b11));
        vecs.push_back(mk(enc_ldi(3'd2, 10'd3),             0, 2, 16'h0003, 16'd2,  16'h0000, 16'h0003, 2'b11));
        vecs.push_back(mk(enc_rrr(3'b000, 3'd3, 3'd1, 3'd2), 0, 3, 16'h0008, 16'd3,  16'h0005, 16'h0003, 2'b00));
        vecs.push_back(mk(enc_ldi(3'd1, 10'h3FF),           0, 1, 16'hFFFF, 16'd4,  16'h0005, 16'hFFFF, 2'b11));
        vecs.push_back(mk(enc_rrr(3'b001, 3'd4, 3'd1, 3'd1), 0, 4, 16'h0000, 16'd5,  16'hFFFF, 16'hFFFF, 2'b01));
        vecs.push_back(mk(enc_ldi(3'd1, 10'h0FF),           0, 1, 16'h00FF, 16'd6,  16'hFFFF, 16'h00FF, 2'b11));
        vecs.push_back(mk(enc_ldi(3'd2, 10'h1E1),           0, 2, 16'h01E1, 16'd7,  16'hFFFF, 16'h01E1, 2'b11));
        vecs.push_back(mk(enc_rrr(3'b000, 3'd2, 3'd2, 3'd2), 0, 2, 16'h03C2, 16'd8,  16'h01E1, 16'h01E1, 2'b00));
        vecs.push_back(mk(enc_rrr(3'b000, 3'd2, 3'd2, 3'd2), 0, 2, 16'h0784, 16'd9,  16'h03C2, 16'h03C2, 2'b00));
        vecs.push_back(mk(enc_rrr(3'b000, 3'd2, 3'd2, 3'd2), 0, 2, 16'h0F08, 16'd10, 16'h0784, 16'h0784, 2'b00));
        vecs.push_back(mk(enc_ldi(3'd6, 10'd7),             0, 6, 16'h0007, 16'd11, 16'h0784, 16'h0007, 2'b11));
        vecs.push_back(mk(enc_rrr(3'b000, 3'd2, 3'd2, 3'd6), 0, 2, 16'h0F0F, 16'd12, 16'h0F08, 16'h0007, 2'b00));
        vecs.push_back(mk(enc_rrr(3'b010, 3'd5, 3'd1, 3'd2), 0, 5, 16'hFFF0, 16'd13, 16'h00FF, 16'h0F0F, 2'b10));
        vecs.push_back(mk(enc_rrr(3'b110, 3'd1, 3'd2, 3'd3), 1, 0, 16'h0000, 16'd13, 16'h00FF, 16'h0F0F, 2'b10));
        vecs.push_back(mk(enc_rrr(3'b101, 3'd7, 3'd7, 3'd7), 1, 0, 16'h0000, 16'd13, 16'h00FF, 16'h0F0F, 2'b10));
        vecs.push_back(mk(enc_rrr(3'b111, 3'd0, 3'd5, 3'd4), 1, 0, 16'h0000, 16'd13, 16'h00FF, 16'h0F0F, 2'b10));
        vecs.push_back(mk(enc_ldi(3'd7, 10'h200),           0, 7, 16'hFE00, 16'd14, 16'h00FF, 16'hFE00, 2'b11));
        vecs.push_back(mk(enc_rrr(3'b000, 3'd7, 3'd7, 3'd7), 0, 7, 16'hFC00, 16'd15, 16'hFE00, 16'hFE00, 2'b00));
        vecs.push_back(mk(enc_rrr(3'b011, 3'd3, 3'd1, 3'd5), 0, 3, 16'hFFF0, 16'd16, 16'h00FF, 16'hFFF0, 2'b11));
        vecs.push_back(mk(enc_ldi(3'd0, 10'd7),             0, 0, 16'h0007, 16'd17, 16'h00FF, 16'h0007, 2'b11));
        vecs.push_back(mk(enc_rrr(3'b000, 3'd1, 3'd0, 3'd0), 0, 1, R0_SUM,   16'd18, R0_VAL,   R0_VAL,   2'b00));

        // Reset state.
        rstN           = 1'b0;
        ifc.instrValid = 1'b0;
        ifc.instrIn    = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", ifc.instrReady, 1);
        check("rst_wbvalid", ifc.wbValid, 0);
        check("rst_err", ifc.errIllegal, 0);
        check("rst_retired", ifc.retired, 0);
        check("rst_opA", ifc.rdDataA, 0);
        check("rst_wbdata", ifc.wbData, 0);
        rstN = 1'b1;
        @(negedge clk);

        // Idle with instrValid low: nothing happens.
        @(negedge clk);
        check("idle_ready", ifc.instrReady, 1);
        check("idle_retired", ifc.retired, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset while an instruction is in EXEC.
        wait_ready("rstx");
        ifc.instrIn    = enc_rrr(3'b000, 3'd3, 3'd1, 3'd2);
        ifc.instrValid = 1'b1;
        @(negedge clk);
        ifc.instrValid = 1'b0;
        @(negedge clk);                       // now in EXEC
        check("rstx_in_exec", ifc.instrReady, 0);
        rstN = 1'b0;
        #1;
        check("rstx_ready_now", ifc.instrReady, 1);
        check("rstx_wbvalid", ifc.wbValid, 0);
        check("rstx_retired", ifc.retired, 0);
        check("rstx_opA", ifc.rdDataA, 0);
        check("rstx_opB", ifc.rdDataB, 0);
        check("rstx_opsel", ifc.opSelect, 0);
        check("rstx_wbaddr", ifc.wbAddr, 0);
        check("rstx_wbdata", ifc.wbData, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rstx_no_write", ifc.wbValid, 0);
        end
        rstN = 1'b1;
        @(negedge clk);

        // Every register reads zero: pass-B of R[i] into R[i].
        for (int i = 0; i < 8; i++) begin
            run_vec(100 + i, mk(enc_rrr(3'b011, 3'(i), 3'(i), 3'(i)), 0, 3'(i), 16'h0000,
                                16'(i + 1), 16'h0000, 16'h0000, 2'b11));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
